lane_unstriper: RTL and testbench

- Parametrised N-lane to 1-stream byte unstriper for the PCIe PHY receive path, single clock domain.
- Accepts one frame per handshake: NUM_LANES lanes of DATA_W bits, each with a valid bit.
- Emits the lanes serially, lane 0 first, one lane per clock.
- Two-entry frame buffer sustains back-to-back frames with no bubble; optional skip mode compresses out invalid lanes.

---
 rtl/lane_unstriper_pkg.sv | 7 +
 rtl/lane_unstriper_lane_pick.sv | 22 ++
 rtl/lane_unstriper.sv | 115 +++++++++++
 tb/tb_lane_unstriper.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/lane_unstriper_pkg.sv
// lane_unstriper_pkg: shared PHY lane defaults, skip-mode encoding and serializer states
package lane_unstriper_pkg;
    localparam int DEF_NUM_LANES = 4;
    localparam int DEF_DATA_W    = 8;
    typedef enum logic {MODE_FULL = 1'b0, MODE_SKIP = 1'b1} mode_e;
    typedef enum logic {IDLE = 1'b0, SER = 1'b1} state_e;
endpackage

// File: rtl/lane_unstriper_lane_pick.sv
// lane_pick: lowest set bit of a lane mask at or above a start index
module lane_pick
    import lane_unstriper_pkg::*;
#(
    parameter int NUM_LANES = DEF_NUM_LANES
) (
    input  logic [NUM_LANES-1:0]         mask_i,
    input  logic [$clog2(NUM_LANES)-1:0] start_i,
    output logic [$clog2(NUM_LANES)-1:0] idx_o,
    output logic                         found_o
);
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (mask_i[i] && i >= int'(start_i)) begin
                idx_o   = ($clog2(NUM_LANES))'(i);
                found_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/lane_unstriper.sv
// lane_unstriper: N-lane frame to serial byte stream with two-entry frame buffer and optional invalid-lane skipping
module lane_unstriper
    import lane_unstriper_pkg::*;
#(
    parameter int NUM_LANES = DEF_NUM_LANES,
    parameter int DATA_W    = DEF_DATA_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_LANES*DATA_W-1:0] in_data,
    input  logic [NUM_LANES-1:0]        in_lane_valid,
    input  logic                        in_load,
    input  logic                        skip_mode,
    output logic                        in_ready,
    output logic [DATA_W-1:0]           out,
    output logic                        validout,
    output logic                        busy
);
    localparam int IDX_W = $clog2(NUM_LANES);

    state_e                      state_q, state_d;
    logic [NUM_LANES*DATA_W-1:0] act_data_q, act_data_d, pend_data_q, pend_data_d;
    logic [NUM_LANES-1:0]        act_vld_q, act_vld_d, pend_vld_q, pend_vld_d, load_vld;
    mode_e                       act_mode_q, act_mode_d, pend_mode_q, pend_mode_d, load_mode;
    logic                        pend_full_q, pend_full_d;
    logic [IDX_W-1:0]            idx_q, idx_d, nxt_idx, first_idx;
    logic [DATA_W-1:0]           out_q, out_d;
    logic                        validout_q, validout_d;
    logic                        nxt_found, first_found, cur_vld, last, done;
    logic                        accept, free, take_pend, load_act, load_pend;

    assign in_ready  = !pend_full_q;
    assign busy      = state_q == SER;
    assign out       = out_q;
    assign validout  = validout_q;
    assign accept    = in_load && in_ready;
    assign cur_vld   = act_vld_q[idx_q];
    assign last      = idx_q == IDX_W'(NUM_LANES - 1) || (act_mode_q == MODE_SKIP && !nxt_found);
    assign done      = busy && last;
    assign free      = !busy || done;
    assign take_pend = free && pend_full_q;
    assign load_act  = free && (pend_full_q || accept);
    // A new frame lands in pending when active stays occupied, including when pending itself is promoted.
    assign load_pend = accept && (take_pend || !free);
    assign load_vld  = pend_full_q ? pend_vld_q : in_lane_valid;
    assign load_mode = pend_full_q ? pend_mode_q : mode_e'(skip_mode);

    lane_pick #(.NUM_LANES(NUM_LANES)) u_pick_next (
        .mask_i (act_vld_q),
        .start_i(idx_q + 1'b1),
        .idx_o  (nxt_idx),
        .found_o(nxt_found)
    );

    lane_pick #(.NUM_LANES(NUM_LANES)) u_pick_first (
        .mask_i (load_vld),
        .start_i('0),
        .idx_o  (first_idx),
        .found_o(first_found)
    );

    always_comb begin
        state_d     = state_q;
        act_data_d  = act_data_q;
        act_vld_d   = act_vld_q;
        act_mode_d  = act_mode_q;
        pend_data_d = load_pend ? in_data : pend_data_q;
        pend_vld_d  = load_pend ? in_lane_valid : pend_vld_q;
        pend_mode_d = load_pend ? mode_e'(skip_mode) : pend_mode_q;
        pend_full_d = load_pend || (pend_full_q && !take_pend);
        idx_d       = idx_q;
        out_d       = busy && cur_vld ? act_data_q[idx_q*DATA_W +: DATA_W] : '0;
        validout_d  = busy && cur_vld;
        if (busy)
            idx_d = act_mode_q == MODE_SKIP ? nxt_idx : idx_q + 1'b1;
        if (load_act) begin
            state_d    = SER;
            act_data_d = pend_full_q ? pend_data_q : in_data;
            act_vld_d  = load_vld;
            act_mode_d = load_mode;
            idx_d      = load_mode == MODE_SKIP && first_found ? first_idx : '0;
        end else if (done) begin
            state_d = IDLE;
            idx_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            act_data_q  <= '0;
            act_vld_q   <= '0;
            act_mode_q  <= MODE_FULL;
            pend_data_q <= '0;
            pend_vld_q  <= '0;
            pend_mode_q <= MODE_FULL;
            pend_full_q <= 1'b0;
            idx_q       <= '0;
            out_q       <= '0;
            validout_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            act_data_q  <= act_data_d;
            act_vld_q   <= act_vld_d;
            act_mode_q  <= act_mode_d;
            pend_data_q <= pend_data_d;
            pend_vld_q  <= pend_vld_d;
            pend_mode_q <= pend_mode_d;
            pend_full_q <= pend_full_d;
            idx_q       <= idx_d;
            out_q       <= out_d;
            validout_q  <= validout_d;
        end
    end
endmodule

// File: tb/tb_lane_unstriper.sv
// tb_lane_unstriper: scoreboard-checked scenarios for lane_unstriper with 4 lanes of 8 bits
module tb_lane_unstriper;
    localparam int NL = 4;
    localparam int DW = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NL*DW-1:0]  in_data = '0;
    logic [NL-1:0]     in_lane_valid = '0;
    logic              in_load = 1'b0;
    logic              skip_mode = 1'b0;
    logic              in_ready, validout, busy;
    logic [DW-1:0]     out;
    logic [DW-1:0]     exp_q [$];
    logic [DW-1:0]     sb_exp;
    int                n_vec = 0;
    int                n_err = 0;

    lane_unstriper #(.NUM_LANES(NL), .DATA_W(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_lane_valid(in_lane_valid),
        .in_load      (in_load),
        .skip_mode    (skip_mode),
        .in_ready     (in_ready),
        .out          (out),
        .validout     (validout),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (validout === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_extra: out=%h emitted, no lane expected", out);
            end else begin
                sb_exp = exp_q.pop_front();
                if (out !== sb_exp) begin
                    n_err++;
                    $display("FAIL sb_data: out=%h expected %h", out, sb_exp);
                end
            end
        end
    end

    task automatic offer(input logic [NL*DW-1:0] d, input logic [NL-1:0] v, input logic s);
        in_data = d;
        in_lane_valid = v;
        skip_mode = s;
        in_load = 1'b1;
    endtask

    task automatic push_frame(input logic [NL*DW-1:0] d, input logic [NL-1:0] v);
        for (int i = 0; i < NL; i++)
            if (v[i]) exp_q.push_back(d[i*DW +: DW]);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_load = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if (out !== '0) begin n_err++; $display("FAIL rst_out: got %h expected 00", out); end
        n_vec++; if (validout !== 1'b0) begin n_err++; $display("FAIL rst_validout: got %b expected 0", validout); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b expected 0", busy); end
        reset = 1'b0;
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_full_single();
        offer(32'hA3A2A1A0, 4'hF, 1'b0);
        push_frame(32'hA3A2A1A0, 4'hF);
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fs_ready: got %b expected 1", in_ready); end
        @(negedge clk);
        in_load = 1'b0;
        n_vec++; if (validout !== 1'b0) begin n_err++; $display("FAIL fs_latency: validout %b expected 0", validout); end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_vec++; if (validout !== 1'b1) begin n_err++; $display("FAIL fs_valid lane %0d: got %b expected 1", c, validout); end
        end
        @(negedge clk);
        n_vec++; if ({busy, validout, out} !== 10'h0) begin n_err++; $display("FAIL fs_idle: busy=%b validout=%b out=%h expected 0 0 00", busy, validout, out); end
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL fs_drain: %0d lanes left expected 0", exp_q.size()); end
    endtask

    task automatic test_full_holes();
        logic [8:0] exp_t [4];
        exp_t = '{9'h000, 9'h122, 9'h000, 9'h144};
        offer(32'h44332211, 4'b1010, 1'b0);
        push_frame(32'h44332211, 4'b1010);
        @(negedge clk);
        in_load = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_vec++; if ({validout, out} !== exp_t[c]) begin n_err++; $display("FAIL fh_slot %0d: got %h expected %h", c, {validout, out}, exp_t[c]); end
        end
        @(negedge clk);
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL fh_drain: %0d lanes left expected 0", exp_q.size()); end
    endtask

    task automatic test_skip();
        logic [8:0] exp_t [5];
        exp_t = '{9'h000, 9'h122, 9'h144, 9'h155, 9'h000};
        offer(32'h44332211, 4'b1010, 1'b1);
        push_frame(32'h44332211, 4'b1010);
        @(negedge clk);
        n_vec++; if ({validout, out} !== exp_t[0]) begin n_err++; $display("FAIL sk_slot 0: got %h expected %h", {validout, out}, exp_t[0]); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL sk_ready: got %b expected 1", in_ready); end
        offer(32'h88776655, 4'b0001, 1'b1);
        push_frame(32'h88776655, 4'b0001);
        for (int c = 1; c < 5; c++) begin
            @(negedge clk);
            in_load = 1'b0;
            in_lane_valid = 4'hF;
            skip_mode = 1'b0;
            n_vec++; if ({validout, out} !== exp_t[c]) begin n_err++; $display("FAIL sk_slot %0d: got %h expected %h", c, {validout, out}, exp_t[c]); end
        end
        offer(32'h77777777, 4'b0000, 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_load = 1'b0;
            n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL sk_empty_ready %0d: got %b expected 1", c, in_ready); end
            n_vec++; if (validout !== 1'b0) begin n_err++; $display("FAIL sk_empty_valid %0d: got %b out=%h expected 0", c, validout, out); end
        end
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL sk_drain: %0d lanes left expected 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        int acc = 0;
        logic [NL*DW-1:0] d;
        logic rdy_exp;
        for (int c = 0; c < 16; c++) begin
            rdy_exp = !((c >= 2 && c <= 4) || (c >= 6 && c <= 8));
            if (c <= 12) begin
                n_vec++; if (in_ready !== rdy_exp) begin n_err++; $display("FAIL bb_ready cycle %0d: got %b expected %b", c, in_ready, rdy_exp); end
            end
            if (c >= 2 && c <= 13) begin
                n_vec++; if (validout !== 1'b1) begin n_err++; $display("FAIL bb_gap cycle %0d: validout %b expected 1", c, validout); end
            end
            if (acc < 3) begin
                for (int i = 0; i < NL; i++) d[i*DW +: DW] = 8'(176 + 4 * acc + i);
                offer(d, 4'hF, 1'b0);
                if (in_ready === 1'b1) begin
                    push_frame(d, 4'hF);
                    acc++;
                end
            end else in_load = 1'b0;
            @(negedge clk);
        end
        n_vec++; if (acc != 3) begin n_err++; $display("FAIL bb_accepts: got %0d expected 3", acc); end
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL bb_drain: %0d lanes left expected 0", exp_q.size()); end
    endtask

    task automatic test_blocked_offer();
        offer(32'h0D0C0B0A, 4'hF, 1'b0);
        push_frame(32'h0D0C0B0A, 4'hF);
        @(negedge clk);
        offer(32'h1D1C1B1A, 4'hF, 1'b0);
        push_frame(32'h1D1C1B1A, 4'hF);
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bo_ready: got %b expected 0", in_ready); end
        offer(32'hEEEEEEEE, 4'hF, 1'b0);
        repeat (2) @(negedge clk);
        in_load = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_vec++; if (validout === 1'b1 && out === 8'hEE) begin n_err++; $display("FAIL bo_leak cycle %0d: out=%h expected not EE", c, out); end
        end
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL bo_drain: %0d lanes left expected 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        offer(32'h53525150, 4'hF, 1'b0);
        push_frame(32'h53525150, 4'hF);
        @(negedge clk);
        offer(32'h63626160, 4'hF, 1'b0);
        push_frame(32'h63626160, 4'hF);
        @(negedge clk);
        in_load = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        n_vec++; if ({busy, validout, out} !== 10'h0) begin n_err++; $display("FAIL rm_async: busy=%b validout=%b out=%h expected 0 0 00", busy, validout, out); end
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rm_ready: got %b expected 1", in_ready); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rm_busy: got %b expected 0", busy); end
        offer(32'h04030201, 4'hF, 1'b0);
        push_frame(32'h04030201, 4'hF);
        @(negedge clk);
        in_load = 1'b0;
        @(negedge clk);
        n_vec++; if ({validout, out} !== 9'h101) begin n_err++; $display("FAIL rm_lane0: got %h expected 101", {validout, out}); end
        repeat (5) @(negedge clk);
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rm_drain: %0d lanes left expected 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_full_single();
        test_full_holes();
        test_skip();
        test_back_to_back();
        test_blocked_offer();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
